// File: rtl/gray_pkg.sv
// Shared Gray-domain helpers and constants.
// Used by the counter and by other blocks that work with Gray codes.
package gray_pkg;

    // Widest value the shared conversion function handles.
    localparam int GRAY_MAX_W = 64;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Narrower callers zero-extend their operand and truncate the result.
    // The shifted-in zero at the top keeps the low bits correct for any width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_bin2gray.sv
// Combinational binary-to-Gray converter.
// This is the inverse of the Gray-to-binary converter that sits downstream.
module bin2gray
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_bin,
    output logic [DATA_WIDTH-1:0] o_gray
);

    logic [GRAY_MAX_W-1:0] w_bin_ext;
    logic [GRAY_MAX_W-1:0] w_gray_ext;

    assign w_bin_ext  = GRAY_MAX_W'(i_bin);
    assign w_gray_ext = gray_pkg::bin2gray(w_bin_ext);
    assign o_gray     = w_gray_ext[DATA_WIDTH-1:0];

endmodule

// File: rtl/gray_counter.sv
// Up/down counter kept in binary and presented as registered Gray code.
// The Gray register is loaded from the converted next-state value, so the output needs no XOR after the flop.
module gray_counter
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WRAP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_bin,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  wrap_p
);

    localparam logic [DATA_WIDTH-1:0] CNT_ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] CNT_ZERO     = '0;
    localparam logic [DATA_WIDTH-1:0] CNT_ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    if (DATA_WIDTH < 2 || DATA_WIDTH > GRAY_MAX_W) begin : g_bad_width
        $error("gray_counter: DATA_WIDTH out of range");
    end

    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_gcnt;
    logic                  r_wrap_p;

    logic [DATA_WIDTH-1:0] w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_gcnt_nxt;
    logic                  w_wrap_nxt;
    logic                  w_at_max;
    logic                  w_at_min;

    // Wrap/saturate decisions come from these decodes, never from the adder carry.
    assign w_at_max = (r_cnt == CNT_ALL_ONES);
    assign w_at_min = (r_cnt == CNT_ZERO);

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_cnt_nxt = load_bin;
        end else if (en && (up_dn == CNT_UP)) begin
            if (w_at_max) begin
                if (WRAP != 0) begin
                    w_cnt_nxt  = CNT_ZERO;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
        end else if (en) begin
            if (w_at_min) begin
                if (WRAP != 0) begin
                    w_cnt_nxt  = CNT_ALL_ONES;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt - CNT_ONE;
            end
        end
    end

    bin2gray #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bin2gray (
        .i_bin  (w_cnt_nxt),
        .o_gray (w_gcnt_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= CNT_ZERO;
            r_gcnt   <= CNT_ZERO;
            r_wrap_p <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_gcnt   <= w_gcnt_nxt;
            r_wrap_p <= w_wrap_nxt;
        end
    end

    assign bin_out  = r_cnt;
    assign gray_out = r_gcnt;
    assign at_max   = w_at_max;
    assign at_min   = w_at_min;
    assign wrap_p   = r_wrap_p;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a wrapping and a saturating 4-bit instance share one stimulus stream.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_bin;

    logic [3:0] b1, g1, b0, g0;
    logic       amax1, amin1, wp1, amax0, amin0, wp0;

    always #5 clk = ~clk;

    gray_counter #(.DATA_WIDTH(4), .WRAP(1)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .bin_out(b1), .gray_out(g1), .at_max(amax1), .at_min(amin1), .wrap_p(wp1)
    );

    gray_counter #(.DATA_WIDTH(4), .WRAP(0)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .bin_out(b0), .gray_out(g0), .at_max(amax0), .at_min(amin0), .wrap_p(wp0)
    );

    typedef struct {
        logic [3:0] b1;
        logic [3:0] g1;
        logic       w1;
        logic [3:0] b0;
        logic [3:0] g0;
        logic       w0;
        bit         estep;
        string      tag;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m1, m0;
    logic [3:0] prev_g1;

    function automatic logic [3:0] tb_b2g(logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] tb_g2b(logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Reference model: returns {wrap_pulse, next_count}.
    function automatic logic [4:0] mnext(logic [3:0] c, bit wrap, bit e, bit u, bit l, logic [3:0] lb);
        if (l) return {1'b0, lb};
        if (!e) return {1'b0, c};
        if (u) begin
            if (c == 4'd15) return wrap ? 5'b1_0000 : {1'b0, c};
            return {1'b0, c + 4'd1};
        end
        if (c == 4'd0) return wrap ? 5'b1_1111 : {1'b0, c};
        return {1'b0, c - 4'd1};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, " bin_wrap"}, 32'(b1), 0);
        chk({tag, " gray_wrap"}, 32'(g1), 0);
        chk({tag, " bin_sat"}, 32'(b0), 0);
        chk({tag, " gray_sat"}, 32'(g0), 0);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; load = 1'b0; up_dn = 1'b1; load_bin = 4'd0;
        #1;
        chk_reset_outputs(tag);
        chk({tag, " at_min"}, 32'(amin1), 1);
        chk({tag, " at_max"}, 32'(amax1), 0);
        chk({tag, " wrap_p"}, 32'({wp1, wp0}), 0);
        m1 = 4'd0; m0 = 4'd0; prev_g1 = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // hsel: 0 = model only, 1 = hand values for wrapping DUT, 2 = hand values for saturating DUT.
    task automatic step(bit e, bit u, bit l, logic [3:0] lb, int hsel,
                        logic [3:0] hb, logic [3:0] hg, logic hw, string tag);
        exp_t       x;
        logic [4:0] r;
        @(negedge clk);
        en = e; up_dn = u; load = l; load_bin = lb;
        r = mnext(m1, 1'b1, e, u, l, lb);
        m1 = r[3:0]; x.b1 = r[3:0]; x.w1 = r[4]; x.g1 = tb_b2g(r[3:0]);
        r = mnext(m0, 1'b0, e, u, l, lb);
        m0 = r[3:0]; x.b0 = r[3:0]; x.w0 = r[4]; x.g0 = tb_b2g(r[3:0]);
        if (hsel == 1) begin
            x.b1 = hb; x.g1 = hg; x.w1 = hw;
        end else if (hsel == 2) begin
            x.b0 = hb; x.g0 = hg; x.w0 = hw;
        end
        x.estep = e && !l;
        x.tag   = tag;
        q.push_back(x);
    endtask

    // Monitor: one expected entry is consumed after each edge that had stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk({x.tag, " bin_wrap"}, 32'(b1), 32'(x.b1));
                chk({x.tag, " gray_wrap"}, 32'(g1), 32'(x.g1));
                chk({x.tag, " wrap_p_wrap"}, 32'(wp1), 32'(x.w1));
                chk({x.tag, " at_max_wrap"}, 32'(amax1), 32'(x.b1 == 4'd15));
                chk({x.tag, " at_min_wrap"}, 32'(amin1), 32'(x.b1 == 4'd0));
                chk({x.tag, " bin_sat"}, 32'(b0), 32'(x.b0));
                chk({x.tag, " gray_sat"}, 32'(g0), 32'(x.g0));
                chk({x.tag, " wrap_p_sat"}, 32'(wp0), 32'(x.w0));
                chk({x.tag, " at_max_sat"}, 32'(amax0), 32'(x.b0 == 4'd15));
                chk({x.tag, " at_min_sat"}, 32'(amin0), 32'(x.b0 == 4'd0));
                chk({x.tag, " gray_consistent"}, 32'(g1), 32'(tb_b2g(b1)));
                chk({x.tag, " g2b_roundtrip"}, 32'(tb_g2b(g1)), 32'(b1));
                if (x.estep)
                    chk({x.tag, " hamming"}, 32'($countones(g1 ^ prev_g1)), 1);
                prev_g1 = g1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total + 1, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] up_gray [16];
        up_gray = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                    4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'd0;

        do_reset("reset");
        for (int k = 0; k < 16; k++)
            step(1, 1, 0, 4'd0, 1, 4'((k + 1) % 16), up_gray[k], (k == 15), $sformatf("up%0d", k + 1));

        do_reset("reset2");
        step(1, 0, 0, 4'd0, 1, 4'd15, 4'd8, 1'b1, "down_wrap");

        step(0, 0, 1, 4'd14, 2, 4'd14, 4'd9, 1'b0, "sat_load14");
        for (int k = 0; k < 3; k++)
            step(1, 1, 0, 4'd0, 2, 4'd15, 4'd8, 1'b0, $sformatf("sat_up%0d", k));
        step(0, 0, 1, 4'd1, 2, 4'd1, 4'd1, 1'b0, "sat_load1");
        for (int k = 0; k < 2; k++)
            step(1, 0, 0, 4'd0, 2, 4'd0, 4'd0, 1'b0, $sformatf("sat_dn%0d", k));

        step(1, 1, 1, 4'd9, 1, 4'd9, 4'd13, 1'b0, "load_prio");

        do_reset("reset3");
        for (int k = 0; k < 7; k++)
            step(1, 1, 0, 4'd0, 0, 4'd0, 4'd0, 1'b0, "to7");
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        m1 = 4'd0; m0 = 4'd0; prev_g1 = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 4'd0, 1, 4'd1, 4'd1, 1'b0, "resume");

        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                 4'($urandom_range(0, 15)), 0, 4'd0, 4'd0, 1'b0, "rand");
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
